// File: rtl/fifo_wr_burst_ctrl.sv
// Write-side burst controller: req/wen/wack handshake, then streams a burst into the FIFO write port with a programmable inter-word gap.
// Latency: 1 cycle from din acceptance (din_valid & din_ready) to the memory write (wclken/waddr/wdata) and the wptr update.
// Backpressure: din_ready drops the same cycle wfull rises and during GAP cycles; optional counters under `WR_BURST_STATS_EN.
module fifo_wr_burst_ctrl #(
    parameter int ADDRSIZE = 10,
    parameter int DATASIZE = 8
) (
    input  logic                wclk,
    input  logic                wrst_n,
    input  logic                req,
    input  logic [ADDRSIZE-1:0] burst_len,
    input  logic [1:0]          widle,
    input  logic [DATASIZE-1:0] din,
    input  logic                din_valid,
    output logic                din_ready,
    output logic                wen,
    input  logic                wack,
    input  logic                wfull,
    output logic                wclken,
    output logic [ADDRSIZE-1:0] waddr,
    output logic [DATASIZE-1:0] wdata,
    output logic [ADDRSIZE:0]   wptr,
    output logic                busy,
    output logic                done
`ifdef WR_BURST_STATS_EN
    ,
    output logic [15:0]         burst_cnt,
    output logic [15:0]         stall_cnt
`endif
);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_XFER, S_GAP, S_DONE} state_t;

    state_t                r_state;
    state_t                w_next;
    logic [ADDRSIZE-1:0]   r_remain;
    logic [1:0]            r_widle;
    logic [1:0]            r_gap;
    logic [ADDRSIZE:0]     r_wbin;
    logic                  r_wclken;
    logic [ADDRSIZE-1:0]   r_waddr;
    logic [DATASIZE-1:0]   r_wdata;
    logic [ADDRSIZE:0]     r_wptr;
    logic                  w_accept;
    logic                  w_start;
    logic [ADDRSIZE:0]     w_wbin_next;
    logic [1:0]            w_widle_eff;

    // A gap request of 3 is clamped to the maximum supported gap of 2.
    assign w_widle_eff = (widle == 2'd3) ? 2'd2 : widle;
    assign w_start     = (r_state == S_IDLE) && req && (burst_len != '0);
    assign w_accept    = (r_state == S_XFER) && din_valid && !wfull;
    assign w_wbin_next = r_wbin + (ADDRSIZE+1)'(1);

    // State register.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    // Next-state and handshake outputs; wen stays high through the whole
    // transfer and is released in DONE to complete the 4-phase handshake.
    always_comb begin
        w_next    = r_state;
        wen       = 1'b0;
        din_ready = 1'b0;
        done      = 1'b0;
        busy      = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (req && burst_len == '0) done = 1'b1;
                if (w_start) w_next = S_REQ;
            end
            S_REQ: begin
                wen = 1'b1;
                if (wack) w_next = S_XFER;
            end
            S_XFER: begin
                wen       = 1'b1;
                din_ready = !wfull;
                if (w_accept) begin
                    if (r_remain == ADDRSIZE'(1)) w_next = S_DONE;
                    else if (r_widle != 2'd0)     w_next = S_GAP;
                end
            end
            S_GAP: begin
                wen = 1'b1;
                if (r_gap == 2'd1) w_next = S_XFER;
            end
            S_DONE: begin
                if (!wack) begin
                    done   = 1'b1;
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Burst bookkeeping: remaining word count, latched gap and gap countdown.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_remain <= '0;
            r_widle  <= 2'd0;
            r_gap    <= 2'd0;
        end else begin
            if (w_start) begin
                r_remain <= burst_len;
                r_widle  <= w_widle_eff;
            end
            if (w_accept) begin
                r_remain <= r_remain - ADDRSIZE'(1);
                r_gap    <= r_widle;
            end else if (r_state == S_GAP) begin
                r_gap <= r_gap - 2'd1;
            end
        end
    end

    // Memory write port and pointers, registered one cycle after acceptance.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_wclken <= 1'b0;
            r_waddr  <= '0;
            r_wdata  <= '0;
            r_wbin   <= '0;
            r_wptr   <= '0;
        end else begin
            r_wclken <= w_accept;
            if (w_accept) begin
                r_waddr <= r_wbin[ADDRSIZE-1:0];
                r_wdata <= din;
                r_wbin  <= w_wbin_next;
                r_wptr  <= (w_wbin_next >> 1) ^ w_wbin_next;
            end
        end
    end

    assign wclken = r_wclken;
    assign waddr  = r_waddr;
    assign wdata  = r_wdata;
    assign wptr   = r_wptr;

`ifdef WR_BURST_STATS_EN
    logic [15:0] r_burst_cnt;
    logic [15:0] r_stall_cnt;

    // Saturating counters of completed bursts and of cycles stalled by wfull.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_burst_cnt <= 16'd0;
            r_stall_cnt <= 16'd0;
        end else begin
            if (done && r_burst_cnt != 16'hFFFF)
                r_burst_cnt <= r_burst_cnt + 16'd1;
            if (r_state == S_XFER && din_valid && wfull && r_stall_cnt != 16'hFFFF)
                r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign burst_cnt = r_burst_cnt;
    assign stall_cnt = r_stall_cnt;
`endif

endmodule
